// File: rtl/hazard_stall_unit_if.sv
// hazard_stall_unit_if: pipeline-to-hazard-unit signal bundle
interface hazard_stall_unit_if;
  logic        ID_Ex_MemtoReg;
  logic [4:0]  ID_Ex_rt;
  logic [4:0]  IF_ID_rs;
  logic [4:0]  IF_ID_rt;
  logic        IF_ID_UseRt;
  logic        Ex_Mem_BrTaken;
  logic        Mem_Busy;
  logic        PCWr;
  logic        IF_ID_Wr;
  logic        IF_ID_Flush;
  logic        ID_Ex_Flush;
  logic        Ex_Mem_Flush;
  logic [1:0]  state;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
  logic        freeze_timeout;
  modport master (
    output ID_Ex_MemtoReg, ID_Ex_rt, IF_ID_rs, IF_ID_rt, IF_ID_UseRt, Ex_Mem_BrTaken, Mem_Busy,
    input  PCWr, IF_ID_Wr, IF_ID_Flush, ID_Ex_Flush, Ex_Mem_Flush, state, stall_cnt, flush_cnt, freeze_timeout
  );
  modport slave (
    input  ID_Ex_MemtoReg, ID_Ex_rt, IF_ID_rs, IF_ID_rt, IF_ID_UseRt, Ex_Mem_BrTaken, Mem_Busy,
    output PCWr, IF_ID_Wr, IF_ID_Flush, ID_Ex_Flush, Ex_Mem_Flush, state, stall_cnt, flush_cnt, freeze_timeout
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use stall, branch flush and memory freeze control with event counters
module hazard_stall_unit (
  input logic clk,
  input logic rst_n,
  hazard_stall_unit_if.slave bus
);
  typedef enum logic [1:0] {RUN = 2'b00, STALL = 2'b01, FLUSH = 2'b10, FREEZE = 2'b11} act_t;
  act_t        st, nxt;
  logic        hazard;
  logic [7:0]  frz_cnt, frz_nxt;
  logic [15:0] stall_q, flush_q;
  logic        to_q;
  // The inserted bubble has MemtoReg=0, so a load-use stall cannot repeat on its own
  assign hazard = bus.ID_Ex_MemtoReg && bus.ID_Ex_rt != 5'd0 &&
                  (bus.ID_Ex_rt == bus.IF_ID_rs || (bus.IF_ID_UseRt && bus.ID_Ex_rt == bus.IF_ID_rt));
  assign frz_nxt = nxt != FREEZE ? 8'd0 : frz_cnt == 8'hFF ? 8'hFF : frz_cnt + 8'd1;
  // Pick this cycle's action by priority and decode it into pipeline controls
  always_comb begin
    nxt = bus.Mem_Busy ? FREEZE : bus.Ex_Mem_BrTaken ? FLUSH : hazard ? STALL : RUN;
    bus.PCWr = nxt == RUN || nxt == FLUSH;
    bus.IF_ID_Wr = nxt == RUN || nxt == FLUSH;
    bus.IF_ID_Flush = nxt == FLUSH;
    bus.ID_Ex_Flush = nxt == FLUSH || nxt == STALL;
    bus.Ex_Mem_Flush = nxt == FLUSH;
  end
  // Remember the action taken for observation in the following cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= RUN;
    else st <= nxt;
  // Saturating event counters and the sticky freeze watchdog
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
      frz_cnt <= '0;
      to_q <= 1'b0;
    end else begin
      if (nxt == STALL && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
      if (nxt == FLUSH && flush_q != 16'hFFFF) flush_q <= flush_q + 16'd1;
      frz_cnt <= frz_nxt;
      to_q <= to_q | (frz_nxt == 8'hFF);
    end
  assign bus.state = st;
  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;
  assign bus.freeze_timeout = to_q;
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: scoreboard bench with a rule-level reference model
module tb_hazard_stall_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  hazard_stall_unit_if bus();
  hazard_stall_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic [39:0] sb[$];

  logic [1:0] m_state = 2'd0;
  int m_stall = 0, m_flush = 0, m_run = 0;
  bit m_to = 1'b0;
  logic [1:0] m_act = 2'd0;
  bit m_have = 1'b0;

  function automatic logic [1:0] ref_act(bit mr, logic [4:0] ert, logic [4:0] rs, logic [4:0] rt, bit use_rt, bit br, bit busy);
    bit load_use;
    load_use = mr && ert != 0 && (ert == rs || (use_rt && ert == rt));
    if (busy) return 2'd3;
    if (br) return 2'd2;
    if (load_use) return 2'd1;
    return 2'd0;
  endfunction

  task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 2'd0; m_stall = 0; m_flush = 0; m_run = 0; m_to = 1'b0; m_have = 1'b0;
  endtask

  task automatic apply_edge();
    if (!m_have) return;
    m_state = m_act;
    if (m_act == 2'd1) m_stall = m_stall < 65535 ? m_stall + 1 : 65535;
    if (m_act == 2'd2) m_flush = m_flush < 65535 ? m_flush + 1 : 65535;
    if (m_act == 2'd3) begin
      m_run++;
      if (m_run >= 255) m_to = 1'b1;
    end else m_run = 0;
  endtask

  task automatic cycle(bit mr, logic [4:0] ert, logic [4:0] rs, logic [4:0] rt, bit use_rt, bit br, bit busy);
    logic [1:0] a;
    bit run_like;
    @(posedge clk);
    #1;
    apply_edge();
    bus.ID_Ex_MemtoReg = mr; bus.ID_Ex_rt = ert; bus.IF_ID_rs = rs; bus.IF_ID_rt = rt;
    bus.IF_ID_UseRt = use_rt; bus.Ex_Mem_BrTaken = br; bus.Mem_Busy = busy;
    a = ref_act(mr, ert, rs, rt, use_rt, br, busy);
    run_like = a == 2'd0 || a == 2'd2;
    sb.push_back({run_like, run_like, a == 2'd2, a == 2'd2 || a == 2'd1, a == 2'd2,
                  m_state, 16'(m_stall), 16'(m_flush), m_to});
    m_act = a;
    m_have = 1'b1;
  endtask

  task automatic idle();
    cycle(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    logic [39:0] e, g;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      g = {bus.PCWr, bus.IF_ID_Wr, bus.IF_ID_Flush, bus.ID_Ex_Flush, bus.Ex_Mem_Flush,
           bus.state, bus.stall_cnt, bus.flush_cnt, bus.freeze_timeout};
      n_chk++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL scoreboard at %0t: got %h expected %h", $time, g, e);
      end
    end
  end

  initial begin
    bus.ID_Ex_MemtoReg = 1'b0; bus.ID_Ex_rt = '0; bus.IF_ID_rs = '0; bus.IF_ID_rt = '0;
    bus.IF_ID_UseRt = 1'b0; bus.Ex_Mem_BrTaken = 1'b0; bus.Mem_Busy = 1'b0;
    #2;
    check("reset_state", 32'(bus.state), 32'd0);
    check("reset_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    check("reset_flush_cnt", 32'(bus.flush_cnt), 32'd0);
    check("reset_timeout", 32'(bus.freeze_timeout), 32'd0);
    #10 rst_n = 1'b1;
    model_reset();
    cycle(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    idle();
    check("load_use_stall_cnt", 32'(bus.stall_cnt), 32'd1);
    check("load_use_state_stall", 32'(bus.state), 32'd1);
    cycle(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    idle();
    check("r0_no_stall", 32'(bus.stall_cnt), 32'd1);
    cycle(1'b1, 5'd7, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0);
    idle();
    check("branch_flush_cnt", 32'(bus.flush_cnt), 32'd1);
    check("branch_no_stall", 32'(bus.stall_cnt), 32'd1);
    for (int i = 0; i < 255; i++)
      cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    check("timeout_before_255", 32'(bus.freeze_timeout), 32'd0);
    idle();
    check("timeout_at_255", 32'(bus.freeze_timeout), 32'd1);
    idle();
    check("timeout_sticky", 32'(bus.freeze_timeout), 32'd1);
    for (int i = 0; i < 10; i++) cycle(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_state", 32'(bus.state), 32'd0);
    check("async_rst_stall", 32'(bus.stall_cnt), 32'd0);
    check("async_rst_flush", 32'(bus.flush_cnt), 32'd0);
    check("async_rst_timeout", 32'(bus.freeze_timeout), 32'd0);
    check("async_rst_comb_freeze", 32'(bus.PCWr), 32'd0);
    bus.Mem_Busy = 1'b0;
    #1 rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3000; i++)
      cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
    for (int i = 0; i < 65536; i++) cycle(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    idle();
    check("stall_cnt_saturated", 32'(bus.stall_cnt), 32'h0000FFFF);
    idle();
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
